booth_mac_acc: RTL and testbench

//  Sequential multiply-accumulate back end sitting directly downstream of the 8x8

---
 rtl/booth_mac_acc.sv | 137 +++++++++++++
 tb/tb_booth_mac_acc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_acc.sv
// Saturating multiply-accumulate back end for the 8x8 radix-4 Booth multiplier.
// Sums a programmed count of signed 16-bit products and holds the result until it is accepted.
module booth_mac_acc #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    prod_valid,
    input  logic signed [15:0]      prod,
    output logic                    prod_ready,
    output logic                    acc_valid,
    output logic signed [ACC_W-1:0] acc_out,
    input  logic                    acc_ready,
    output logic                    busy,
    output logic                    ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

    // Returns {saturated_flag, clamped_sum}; one guard bit detects overflow.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [15:0] p);
        logic [ACC_W:0] sum_v;
        sum_v = {a[ACC_W-1], a} + {{(ACC_W-15){p[15]}}, p};
        if (sum_v[ACC_W] != sum_v[ACC_W-1]) begin
            if (sum_v[ACC_W]) begin
                return {1'b1, ACC_MIN};
            end else begin
                return {1'b1, ACC_MAX};
            end
        end else begin
            return {1'b0, sum_v[ACC_W-1:0]};
        end
    endfunction

    logic [1:0]       state_r, state_s;
    logic [ACC_W-1:0] acc_r, acc_s;
    logic [ACC_W-1:0] acc_out_r, acc_out_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic             ovf_r, ovf_s;
    logic             prod_ready_r, acc_valid_r, busy_r;
    logic             transfer_s;
    logic [ACC_W:0]   sat_s;

    assign transfer_s = prod_valid & prod_ready_r;
    assign sat_s      = sat_add(acc_r, prod);

    // Next-state, accumulator and count update logic.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        acc_out_s = acc_out_r;
        cnt_s     = cnt_r;
        ovf_s     = ovf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_s = {ACC_W{1'b0}};
                    ovf_s = 1'b0;
                    if (len != CNT_ZERO) begin
                        cnt_s   = len;
                        state_s = ACCUM;
                    end else begin
                        acc_out_s = {ACC_W{1'b0}};
                        state_s   = HOLD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (transfer_s) begin
                    acc_s = sat_s[ACC_W-1:0];
                    ovf_s = ovf_r | sat_s[ACC_W];
                    cnt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        acc_out_s = sat_s[ACC_W-1:0];
                        state_s   = HOLD;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                if (acc_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers; handshake flags are decoded from the next state so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            acc_out_r    <= {ACC_W{1'b0}};
            cnt_r        <= CNT_ZERO;
            ovf_r        <= 1'b0;
            prod_ready_r <= 1'b0;
            acc_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            acc_out_r    <= acc_out_s;
            cnt_r        <= cnt_s;
            ovf_r        <= ovf_s;
            prod_ready_r <= (state_s == ACCUM);
            acc_valid_r  <= (state_s == HOLD);
            busy_r       <= (state_s != IDLE);
        end
    end

    assign prod_ready = prod_ready_r;
    assign acc_valid  = acc_valid_r;
    assign acc_out    = acc_out_r;
    assign busy       = busy_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: a 24-bit and a 16-bit accumulator share one stimulus stream.
module tb_booth_mac_acc;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               prod_valid;
    logic signed [15:0] prod;
    logic               acc_ready;

    logic               pr24, av24, bz24, ov24;
    logic signed [23:0] acc24;
    logic               pr16, av16, bz16, ov16;
    logic signed [15:0] acc16;

    int nerr;
    int ncheck;
    int tag;

    booth_mac_acc #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(pr24),
        .acc_valid(av24), .acc_out(acc24), .acc_ready(acc_ready),
        .busy(bz24), .ovf(ov24)
    );

    booth_mac_acc #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(pr16),
        .acc_valid(av16), .acc_out(acc16), .acc_ready(acc_ready),
        .busy(bz16), .ovf(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int gap;
        int p0;
        int p1;
        int p2;
        int p3;
        int exp24;
        int ovf24;
        int exp16;
        int ovf16;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        ncheck++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s (seq %0d): got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int pv[4];
        pv[0] = v.p0;
        pv[1] = v.p1;
        pv[2] = v.p2;
        pv[3] = v.p3;
        start = 1'b1;
        len   = v.len[7:0];
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", int'(bz24), 1);
        chk("prod_ready_run", int'(pr24), 1);
        chk("ovf_clr24", int'(ov24), 0);
        chk("ovf_clr16", int'(ov16), 0);
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                prod_valid = 1'b0;
                repeat (v.gap) @(negedge clk);
            end
            prod_valid = 1'b1;
            prod       = pv[i][15:0];
            @(negedge clk);
            if (i < v.len - 1) chk("acc_valid_early", int'(av24), 0);
        end
        prod_valid = 1'b0;
        chk("acc_valid24", int'(av24), 1);
        chk("acc_valid16", int'(av16), 1);
        chk("prod_ready_hold", int'(pr24), 0);
        chk("acc_out24", int'(acc24), v.exp24);
        chk("ovf24", int'(ov24), v.ovf24);
        chk("acc_out16", int'(acc16), v.exp16);
        chk("ovf16", int'(ov16), v.ovf16);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("acc_valid_drop", int'(av24), 0);
        chk("busy_idle", int'(bz24), 0);
        chk("acc_out_kept", int'(acc24), v.exp24);
    endtask

    initial begin
        nerr   = 0;
        ncheck = 0;
        tag    = 0;
        vecs[0] = '{3, 0, 100, -50, 7, 0, 57, 0, 57, 0};
        vecs[1] = '{2, 4, 16384, -16384, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{3, 0, 16384, 16384, 16384, 0, 49152, 0, 32767, 1};
        vecs[3] = '{1, 0, 5, 0, 0, 0, 5, 0, 5, 0};
        vecs[4] = '{3, 1, -32768, -32768, -32768, 0, -98304, 0, -32768, 1};
        vecs[5] = '{4, 0, 32767, 32767, -32768, -1, 32765, 0, -2, 1};

        rst        = 1'b1;
        start      = 1'b0;
        len        = 8'd0;
        prod_valid = 1'b0;
        prod       = 16'sd0;
        acc_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_prod_ready", int'(pr24), 0);
        chk("rst_acc_valid", int'(av24), 0);
        chk("rst_busy", int'(bz24), 0);
        chk("rst_ovf", int'(ov24), 0);
        chk("rst_acc_out", int'(acc24), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            tag = k + 1;
            run_vec(vecs[k]);
        end

        // len==0 goes straight to HOLD with a zero result and accepts nothing
        tag        = 10;
        start      = 1'b1;
        len        = 8'd0;
        prod_valid = 1'b1;
        prod       = 16'sd1234;
        @(negedge clk);
        start = 1'b0;
        chk("len0_prod_ready", int'(pr24), 0);
        chk("len0_acc_valid", int'(av24), 1);
        chk("len0_busy", int'(bz24), 1);
        chk("len0_acc24", int'(acc24), 0);
        chk("len0_acc16", int'(acc16), 0);
        @(negedge clk);
        chk("len0_acc24_hold", int'(acc24), 0);
        chk("len0_prod_ready2", int'(pr24), 0);
        prod_valid = 1'b0;
        acc_ready  = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("len0_busy_end", int'(bz24), 0);

        // result held while downstream stalls; start with acc_ready only returns to IDLE
        tag   = 11;
        start = 1'b1;
        len   = 8'd1;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b1;
        prod       = -16'sd300;
        @(negedge clk);
        prod_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_acc_valid", int'(av24), 1);
            chk("stall_acc_out", int'(acc24), -300);
            @(negedge clk);
        end
        start     = 1'b1;
        acc_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        acc_ready = 1'b0;
        chk("stall_release_valid", int'(av24), 0);
        chk("stall_release_busy", int'(bz24), 0);
        @(negedge clk);
        chk("start_not_retaken", int'(bz24), 0);

        // reset in the middle of a run abandons it
        tag   = 12;
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'sd1000;
        @(negedge clk);
        prod = 16'sd2000;
        @(negedge clk);
        prod_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        chk("mid_rst_prod_ready", int'(pr24), 0);
        chk("mid_rst_acc_valid", int'(av24), 0);
        chk("mid_rst_busy", int'(bz24), 0);
        chk("mid_rst_ovf", int'(ov24), 0);
        chk("mid_rst_acc_out", int'(acc24), 0);
        rst = 1'b0;
        @(negedge clk);

        // start pulse during ACCUM does not restart or resize the run
        tag   = 13;
        start = 1'b1;
        len   = 8'd2;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'sd10;
        @(negedge clk);
        start = 1'b1;
        len   = 8'd5;
        prod  = 16'sd20;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b0;
        chk("ign_start_valid", int'(av24), 1);
        chk("ign_start_acc", int'(acc24), 30);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("ign_start_busy", int'(bz24), 0);

        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule
